// File: rtl/gearbox_40_66.sv
`default_nettype none
// ============================================================================
//  Module      : gearbox_40_66
//  Description : RX gearbox. Packs 40-bit SERDES words (bit 0 oldest) into
//                66-bit 64b/66b blocks with a valid strobe. A slip request
//                drops the oldest buffered serial bit so block-lock logic can
//                walk the alignment; further slips are held off for SLIP_HOLD
//                cycles after each accepted one.
//  Revision    : 1.0  initial release
// ============================================================================
module gearbox_40_66 #(
    parameter int SLIP_HOLD = 2
) (
    input  logic        clk,
    input  logic        sclr,
    input  logic [39:0] din,
    input  logic        slip,
    output logic        slip_ack,
    output logic [65:0] dout,
    output logic        dout_valid
);

    localparam int c_HW = (SLIP_HOLD < 1) ? 1 : $clog2(SLIP_HOLD + 1);
    localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(SLIP_HOLD);

    logic [104:0]    r_stor;
    logic [6:0]      r_cnt;
    logic [c_HW-1:0] r_hold;

    logic [104:0]    w_sum;
    logic [104:0]    w_buf;
    logic [6:0]      w_n;
    logic [6:0]      w_n_adj;
    logic            w_slip_ok;
    logic            w_emit;

    // Merge the new word above the valid bits, apply an optional one-bit slip
    // and decide whether a full block is available.  Bits above r_cnt in
    // r_stor are always zero, so a plain OR inserts the new word correctly.
    always_comb begin
        w_slip_ok = slip && (r_hold == '0);
        w_sum     = r_stor | ({65'd0, din} << r_cnt);
        w_n       = r_cnt + 7'd40;
        w_buf     = w_sum;
        w_n_adj   = w_n;
        if (w_slip_ok) begin
            w_buf   = w_sum >> 1;
            w_n_adj = w_n - 7'd1;
        end
        w_emit = (w_n_adj >= 7'd66);
    end

    // Buffer, block output and slip holdoff registers.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_stor     <= '0;
            r_cnt      <= '0;
            r_hold     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            slip_ack   <= 1'b0;
        end else begin
            if (w_slip_ok) begin
                r_hold   <= c_HOLD_LOAD;
                slip_ack <= 1'b1;
            end else begin
                if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end
                slip_ack <= 1'b0;
            end

            if (w_emit) begin
                dout       <= w_buf[65:0];
                dout_valid <= 1'b1;
                r_stor     <= w_buf >> 66;
                r_cnt      <= w_n_adj - 7'd66;
            end else begin
                dout_valid <= 1'b0;
                r_stor     <= w_buf;
                r_cnt      <= w_n_adj;
            end
        end
    end

endmodule
`default_nettype wire
